// File: rtl/crossbar.sv
// Router switch-traversal stage: steers each input port's flit to the output port
// named by its one-hot destination grant, with an optional registered output stage.
module crossbar #(
    parameter        TOPOLOGY                  = "MESH",
    parameter int    V                         = 4,
    parameter int    P                         = 5,
    parameter int    Fpay                      = 32,
    parameter        MUX_TYPE                  = "ONE_HOT",
    parameter int    ADD_PIPREG_AFTER_CROSSBAR = 0,
    parameter        SSA_EN                    = "YES"
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [P*(P-1)-1:0]          granted_dest_port_all,
    input  logic [P*(2+V+Fpay)-1:0]     flit_in_all,
    input  logic [P-1:0]                ssa_flit_wr_all,
    output logic [P*(2+V+Fpay)-1:0]     flit_out_all,
    output logic [P-1:0]                flit_out_we_all
);

    localparam int FW   = 2 + V + Fpay;
    localparam int PM1  = P - 1;
    localparam int IDXW = (P > 1) ? $clog2(P) : 1;

    // The datapath is identical for every topology; only the name is screened here.
    if (!(TOPOLOGY == "MESH" || TOPOLOGY == "TORUS" || TOPOLOGY == "RING" ||
          TOPOLOGY == "LINE" || TOPOLOGY == "FATTREE")) begin : g_unsupported_topology
    end

    logic [FW-1:0]   w_flit_in  [P];
    logic [PM1-1:0]  w_grant_in [P];
    logic [P*FW-1:0] w_flit_out;
    logic [P-1:0]    w_grant_out;
    logic [P-1:0]    w_ssa;
    logic [P-1:0]    w_we;
    logic [P*FW-1:0] r_flit_out;
    logic [P-1:0]    r_we;

    for (genvar gi = 0; gi < P; gi++) begin : g_split
        assign w_flit_in[gi]  = flit_in_all[gi*FW +: FW];
        assign w_grant_in[gi] = granted_dest_port_all[gi*PM1 +: PM1];
    end

    for (genvar go = 0; go < P; go++) begin : g_out
        logic [PM1-1:0] w_req;
        logic [FW-1:0]  w_mux;

        // Request bit j of output go belongs to the j-th input when input go is skipped.
        for (genvar gi = 0; gi < P; gi++) begin : g_req
            if (gi != go) begin : g_bit
                localparam int REQ_IDX = (gi < go) ? gi : gi - 1;
                localparam int GNT_IDX = (go < gi) ? go : go - 1;
                assign w_req[REQ_IDX] = w_grant_in[gi][GNT_IDX];
            end
        end

        assign w_grant_out[go] = |w_req;

        if (MUX_TYPE == "BINARY") begin : g_bin
            logic [IDXW-1:0] w_src;
            // Descending scan so the lowest contributing input is left in w_src.
            always_comb begin
                w_src = '0;
                for (int j = PM1 - 1; j >= 0; j--) begin
                    if (w_req[j]) begin
                        w_src = IDXW'((j < go) ? j : j + 1);
                    end
                end
            end
            assign w_mux = w_grant_out[go] ? w_flit_in[w_src] : '0;
        end else begin : g_onehot
            always_comb begin
                w_mux = '0;
                for (int j = 0; j < PM1; j++) begin
                    w_mux = w_mux | ({FW{w_req[j]}} & w_flit_in[(j < go) ? j : j + 1]);
                end
            end
        end

        assign w_flit_out[go*FW +: FW] = w_mux;
    end

    assign w_ssa = (SSA_EN == "YES") ? ssa_flit_wr_all : '0;
    assign w_we  = w_grant_out | w_ssa;

    // Register is harmless when unused; it is trimmed if the bypass path is selected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flit_out <= '0;
            r_we       <= '0;
        end else begin
            r_flit_out <= w_flit_out;
            r_we       <= w_we;
        end
    end

    assign flit_out_all    = (ADD_PIPREG_AFTER_CROSSBAR != 0) ? r_flit_out : w_flit_out;
    assign flit_out_we_all = (ADD_PIPREG_AFTER_CROSSBAR != 0) ? r_we       : w_we;

endmodule

// File: tb/tb_crossbar.sv
// Directed bench for crossbar: default, BINARY-mux, SSA-disabled and pipelined
// instances share one set of inputs and are checked against hand-computed vectors.
module tb_crossbar;

    localparam int P  = 5;
    localparam int V  = 4;
    localparam int FP = 32;
    localparam int FW = 2 + V + FP;
    localparam int BW = P * FW;

    logic              clk;
    logic              reset;
    logic [P*(P-1)-1:0] grant;
    logic [BW-1:0]     flit_in;
    logic [P-1:0]      ssa;

    logic [BW-1:0]     out_def,  out_bin,  out_nossa,  out_pipe;
    logic [P-1:0]      we_def,   we_bin,   we_nossa,   we_pipe;

    int n_checks = 0;
    int n_errors = 0;

    crossbar u_def (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa), .flit_out_all(out_def), .flit_out_we_all(we_def)
    );

    crossbar #(.MUX_TYPE("BINARY")) u_bin (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa), .flit_out_all(out_bin), .flit_out_we_all(we_bin)
    );

    crossbar #(.SSA_EN("NO")) u_nossa (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa), .flit_out_all(out_nossa), .flit_out_we_all(we_nossa)
    );

    crossbar #(.ADD_PIPREG_AFTER_CROSSBAR(1)) u_pipe (
        .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
        .ssa_flit_wr_all(ssa), .flit_out_all(out_pipe), .flit_out_we_all(we_pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        grant   = '0;
        flit_in = '0;
        ssa     = '0;
    endtask

    task automatic set_port(input int i, input logic [P-2:0] slice, input logic [FW-1:0] flit);
        grant[i*(P-1) +: (P-1)] = slice;
        flit_in[i*FW +: FW]     = flit;
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] bus, input int o,
                                          input logic [FW-1:0] val);
        logic [BW-1:0] b;
        b = bus;
        b[o*FW +: FW] = val;
        return b;
    endfunction

    logic [BW-1:0] exp_bus;
    logic [BW-1:0] exp_perm;

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        check("reset_pipe_flit", out_pipe, '0);
        check("reset_pipe_we", we_pipe, '0);
        @(negedge clk);
        reset = 1'b0;

        // Idle
        #1;
        check("idle_flit", out_def, '0);
        check("idle_we", we_def, '0);
        check("idle_bin_flit", out_bin, '0);

        // Input 0 slice 0001 -> output 1
        @(negedge clk);
        set_port(0, 4'b0001, 38'h0A_DEAD_BEEF);
        #1;
        exp_bus = put('0, 1, 38'h0A_DEAD_BEEF);
        check("s1_flit", out_def, exp_bus);
        check("s1_we", we_def, 5'b00010);
        check("s1_bin_flit", out_bin, exp_bus);
        check("s1_bin_we", we_bin, 5'b00010);

        // Input 3 mapping
        @(negedge clk);
        clear_inputs();
        set_port(3, 4'b1000, 38'h1234);
        #1;
        check("map_3to4_flit", out_def, put('0, 4, 38'h1234));
        check("map_3to4_we", we_def, 5'b10000);
        set_port(3, 4'b0100, 38'h1234);
        #1;
        check("map_3to2_flit", out_def, put('0, 2, 38'h1234));
        check("map_3to2_we", we_def, 5'b00100);
        set_port(3, 4'b0001, 38'h1234);
        #1;
        check("map_3to0_flit", out_bin, put('0, 0, 38'h1234));
        check("map_3to0_we", we_bin, 5'b00001);

        // Full permutation 0->1, 1->2, 2->3, 3->4, 4->0
        @(negedge clk);
        clear_inputs();
        set_port(0, 4'b0001, 38'h10);
        set_port(1, 4'b0010, 38'h11);
        set_port(2, 4'b0100, 38'h12);
        set_port(3, 4'b1000, 38'h13);
        set_port(4, 4'b0001, 38'h14);
        #1;
        exp_perm = put(put(put(put(put('0, 1, 38'h10), 2, 38'h11), 3, 38'h12), 4, 38'h13), 0, 38'h14);
        check("perm_flit", out_def, exp_perm);
        check("perm_we", we_def, 5'b11111);
        check("perm_bin_flit", out_bin, exp_perm);
        check("perm_bin_we", we_bin, 5'b11111);

        // SSA with matching grant
        @(negedge clk);
        clear_inputs();
        ssa = 5'b00100;
        set_port(1, 4'b0010, 38'h55);
        #1;
        check("ssa_flit", out_def, put('0, 2, 38'h55));
        check("ssa_we", we_def, 5'b00100);
        check("ssa_nossa_we", we_nossa, 5'b00100);

        // SSA strobe alone
        @(negedge clk);
        clear_inputs();
        ssa = 5'b01000;
        #1;
        check("ssa_only_we", we_def, 5'b01000);
        check("ssa_only_flit", out_def, '0);
        check("ssa_off_we", we_nossa, 5'b00000);

        // Two inputs to output 2: OR for ONE_HOT, lowest input for BINARY
        @(negedge clk);
        clear_inputs();
        set_port(0, 4'b0010, 38'h0C1);
        set_port(1, 4'b0010, 38'h30A);
        #1;
        check("conflict_onehot", out_def, put('0, 2, 38'h3CB));
        check("conflict_onehot_we", we_def, 5'b00100);
        check("conflict_binary", out_bin, put('0, 2, 38'h0C1));
        check("conflict_binary_we", we_bin, 5'b00100);

        // Pipelined: idle first, then one-cycle latency
        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #1;
        check("pipe_idle_flit", out_pipe, '0);
        set_port(0, 4'b0001, 38'h0A_DEAD_BEEF);
        #1;
        check("pipe_not_yet_we", we_pipe, 5'b00000);
        @(posedge clk);
        #1;
        check("pipe_n1_flit", out_pipe, put('0, 1, 38'h0A_DEAD_BEEF));
        check("pipe_n1_we", we_pipe, 5'b00010);

        // Async reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("pipe_async_rst_flit", out_pipe, '0);
        check("pipe_async_rst_we", we_pipe, '0);

        // Release, then first output one edge after input
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        set_port(0, 4'b0001, 38'h10);
        set_port(1, 4'b0010, 38'h11);
        set_port(2, 4'b0100, 38'h12);
        set_port(3, 4'b1000, 38'h13);
        set_port(4, 4'b0001, 38'h14);
        #1;
        check("pipe_post_rst_hold", we_pipe, 5'b00000);
        @(posedge clk);
        #1;
        check("pipe_perm_flit", out_pipe, exp_perm);
        check("pipe_perm_we", we_pipe, 5'b11111);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/crossbar.md
Name: crossbar

Overview:
- Router switch-traversal stage: moves each input port's selected flit to the output port granted by the switch allocator.
- Sits after the input-port/allocator stage. It takes the registered grant vector, the input-port flit buses and the SSA write strobes, and drives the router output flit buses and write enables.
- Purely datapath. There is an optional output pipeline register.

Parameters:
- TOPOLOGY, "MESH": topology string. Accepted values are "MESH", "TORUS", "RING", "LINE" and "FATTREE". The grant mapping and datapath are the same for all of them.
- V, 4: VCs per port. Flit width Fw = 2+V+Fpay.
- P, 5: router port count.
- Fpay, 32: flit payload width.
- MUX_TYPE, "ONE_HOT": output mux style, "ONE_HOT" (AND-OR) or "BINARY" (encode then index).
- ADD_PIPREG_AFTER_CROSSBAR, 0: 1 adds a register stage on flit_out_all and flit_out_we_all.
- SSA_EN, "YES": "YES" ORs ssa_flit_wr_all into the output write enables. "NO" ignores that input.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset (only affects pipeline register).
- granted_dest_port_all  in  P*(P-1)  per-input one-hot destination grant. Slice i is bits [(i+1)*(P-1)-1 : i*(P-1)].
- flit_in_all  in  P*Fw  input-port flits. Slice i is bits [(i+1)*Fw-1 : i*Fw].
- ssa_flit_wr_all  in  P  per-output SSA write strobe.
- flit_out_all  out  P*Fw  output-port flits, sliced like flit_in_all.
- flit_out_we_all  out  P  per-output write enable.

Behaviour:
- Grant mapping, no U-turn. For input i, bit k of its slice targets output o = k if k<i, else o = k+1.
  - Output o therefore collects bit (o if o<i else o-1) from each input i≠o.
  - Build a P-1-wide request vector per output from this mapping.
- grant_o = OR of the P-1 request bits for output o.
- flit_out[o]:
  - Equals flit_in[i] for the input i whose grant targets o.
  - Equals all-zero when no input targets o.
  - Flit contents (2 header/tail bits, V VC bits, payload) pass through unmodified.
- flit_out_we[o]:
  - SSA_EN="YES": grant_o | ssa_flit_wr_all[o].
  - Otherwise: grant_o.
  - An SSA write carries the flit selected by the grant vector. The upstream stage guarantees the grant is present in that case.
- Multiple inputs granted to the same output is illegal upstream. Defined result:
  - ONE_HOT: bitwise OR of those flits.
  - BINARY: the lowest-index contributing input wins.
  - The write enable is 1 in both cases.
- Both MUX_TYPE settings give identical outputs for legal (≤1-hot per output) stimulus.
- ADD_PIPREG_AFTER_CROSSBAR=0:
  - Outputs are combinational from the inputs, with zero latency.
  - reset has no effect.
- ADD_PIPREG_AFTER_CROSSBAR=1:
  - flit_out_all and flit_out_we_all are registered on posedge clk, giving 1-cycle latency.
  - On reset assertion, asynchronously: flit_out_all = 0 and flit_out_we_all = 0.
  - Reset asserted mid-traffic discards the in-flight flit.
  - First valid output appears one clock after reset release plus input.
- Simultaneous traffic: all P outputs may be driven in the same cycle from distinct inputs, as a full permutation.
- The block holds no other state. Outputs depend only on the current (or previous-cycle, if piped) inputs.

Test Plan:
- Defaults (P=5, V=4, Fpay=32, Fw=38, no pipe).
  - Stimulus: input 0 grant slice = 4'b0001, flit_in[0] = 38'h0A_DEAD_BEEF.
  - Required: flit_out[1] = 38'h0A_DEAD_BEEF, flit_out_we = 5'b00010, all other outputs 0.
- Mapping check.
  - Stimulus: input 3 grant slice = 4'b1000, flit_in[3] = 38'h1234.
  - Required: output 4 gets 38'h1234 with we[4] = 1. Then 4'b0100 routes to output 2, and 4'b0001 routes to output 0.
- Full permutation.
  - Stimulus: inputs 0..4 send to outputs 1, 2, 3, 4, 0 with flits 38'h10..38'h14.
  - Required: flit_out[1..4, 0] = 38'h10..38'h14 in that order, flit_out_we = 5'b11111. Both MUX_TYPE values give identical results.
- SSA.
  - Stimulus: ssa_flit_wr_all = 5'b00100, input 1 grant slice = 4'b0010 (targets output 2), flit_in[1] = 38'h55.
  - Required: flit_out[2] = 38'h55, we = 5'b00100.
  - With SSA_EN="NO" and no grant, ssa strobe 5'b01000 gives we = 0.
- Pipelined (ADD_PIPREG_AFTER_CROSSBAR=1).
  - Stimulus: apply the grant from scenario 1 at cycle n.
  - Required: outputs appear at cycle n+1.
  - Asserting reset asynchronously mid-cycle forces flit_out_all = 0 and flit_out_we_all = 0 immediately, with no clock edge needed.
- Idle: all grants 0, ssa 0 -> flit_out_all = 0, flit_out_we_all = 0.
